// File: rtl/irq_ctrl.sv
// Interrupt request controller: synchronizes and edge-detects request lines,
// latches them as pending, and presents one prioritized request at a time
// to the core's int_sig input with a stable vector index.
module irq_ctrl #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IDX_W       = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               int_sig,
    output logic [IDX_W-1:0]   vec_idx,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy,
    output logic [7:0]         drop_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StService
    } state_e;

    state_e             state_q;
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] req;
    logic [IDX_W-1:0]   win_idx;
    logic               drop;
    logic [7:0]         drop_cnt_q;
    logic               int_sig_q;
    logic [IDX_W-1:0]   vec_idx_q;
    logic               busy_q;

    // Synchronizer chain followed by the prev flop used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge detect, pending next-state, and drop detection.
    always_comb begin
        edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
        clr_mask = '0;
        if (state_q == StReq && int_ack) begin
            clr_mask[vec_idx_q] = 1'b1;
        end
        // A new edge on a bit being cleared wins and is not a drop.
        pending_d = (pending_q & ~clr_mask) | edge_det;
        drop      = |(edge_det & pending_q & ~clr_mask);
    end

    // Lowest enabled pending index wins.
    always_comb begin
        req     = pending_q & irq_en;
        win_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = IDX_W'(unsigned'(i));
            end
        end
    end

    // Pending bits and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            drop_cnt_q <= 8'h00;
        end else begin
            pending_q <= pending_d;
            if (drop && drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'h01;
            end
        end
    end

    // Request FSM with registered int_sig, vec_idx and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            int_sig_q <= 1'b0;
            vec_idx_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        state_q   <= StReq;
                        int_sig_q <= 1'b1;
                        vec_idx_q <= win_idx;
                    end
                end
                StReq: begin
                    // vec_idx frozen; only the ack moves us on.
                    if (int_ack) begin
                        state_q   <= StService;
                        int_sig_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                StService: begin
                    if (int_done) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    int_sig_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign int_sig  = int_sig_q;
    assign vec_idx  = vec_idx_q;
    assign pending  = pending_q;
    assign busy     = busy_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with default parameters.
module tb_irq_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic [3:0] irq_en;
    logic       int_ack;
    logic       int_done;
    logic       int_sig;
    logic [1:0] vec_idx;
    logic [3:0] pending;
    logic       busy;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    irq_ctrl #(
        .NUM_SRC     (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .irq_en   (irq_en),
        .int_ack  (int_ack),
        .int_done (int_done),
        .int_sig  (int_sig),
        .vec_idx  (vec_idx),
        .pending  (pending),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set now are sampled on it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold mask high for exactly one sampling edge.
    task automatic pulse(input logic [3:0] mask);
        irq_in = mask;
        tick();
        irq_in = 4'b0000;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        irq_in   = 4'b0000;
        irq_en   = 4'b1111;
        int_ack  = 1'b0;
        int_done = 1'b0;
        ticks(3);
        rst = 1'b0;

        // Reset values
        check("rst_int_sig", 32'(int_sig), 32'd0);
        check("rst_vec_idx", 32'(vec_idx), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);

        // Single request: latency N+2 pending, N+3 int_sig
        ticks(2);
        pulse(4'b0001);
        tick();
        check("t1_pend_n1", 32'(pending), 32'h0);
        tick();
        check("t1_pend_n2", 32'(pending), 32'h1);
        check("t1_sig_n2", 32'(int_sig), 32'd0);
        tick();
        check("t1_sig_n3", 32'(int_sig), 32'd1);
        check("t1_vec", 32'(vec_idx), 32'd0);
        ticks(2);
        ack();
        check("t1_ack_sig", 32'(int_sig), 32'd0);
        check("t1_ack_pend", 32'(pending), 32'h0);
        check("t1_ack_busy", 32'(busy), 32'd1);
        ack();  // ignored outside REQ
        check("t1_stray_ack_busy", 32'(busy), 32'd1);
        ticks(2);
        done();
        check("t1_done_busy", 32'(busy), 32'd0);
        ticks(2);
        check("t1_idle_sig", 32'(int_sig), 32'd0);

        // Priority and freeze
        pulse(4'b0100);
        tick();
        pulse(4'b0001);
        check("t2_pend_a2", 32'(pending), 32'h4);
        tick();
        check("t2_sig", 32'(int_sig), 32'd1);
        check("t2_vec", 32'(vec_idx), 32'd2);
        tick();
        check("t2_pend_both", 32'(pending), 32'h5);
        check("t2_vec_frozen", 32'(vec_idx), 32'd2);
        irq_en = 4'b0000;  // masking does not retract a presented request
        ticks(2);
        check("t2_sig_masked", 32'(int_sig), 32'd1);
        irq_en = 4'b1111;
        ack();
        check("t2_ack_pend", 32'(pending), 32'h1);
        check("t2_ack_sig", 32'(int_sig), 32'd0);
        tick();
        done();
        check("t2_done_sig_low", 32'(int_sig), 32'd0);
        tick();
        check("t2_rereq_sig", 32'(int_sig), 32'd1);
        check("t2_rereq_vec", 32'(vec_idx), 32'd0);
        ack();
        done();

        // Masking
        irq_en = 4'b1110;
        pulse(4'b0001);
        ticks(4);
        check("t3_pend", 32'(pending), 32'h1);
        check("t3_sig_masked", 32'(int_sig), 32'd0);
        irq_en = 4'b1111;
        tick();
        check("t3_sig_en", 32'(int_sig), 32'd1);
        check("t3_vec", 32'(vec_idx), 32'd0);
        ack();
        done();
        check("t3_drop_none", 32'(drop_cnt), 32'd0);

        // Drops and saturation on source 1
        for (int i = 0; i < 3; i++) begin
            pulse(4'b0010);
            tick();
        end
        ticks(3);
        check("t4_vec", 32'(vec_idx), 32'd1);
        check("t4_drop2", 32'(drop_cnt), 32'h02);
        for (int i = 0; i < 100; i++) begin
            pulse(4'b0010);
            tick();
        end
        ticks(3);
        check("t4_drop102", 32'(drop_cnt), 32'h66);
        for (int i = 0; i < 200; i++) begin
            pulse(4'b0010);
            tick();
        end
        ticks(3);
        check("t4_drop_sat", 32'(drop_cnt), 32'hFF);
        ack();
        check("t4_ack_pend", 32'(pending), 32'h0);
        done();

        // Same-cycle clear and set on source 3
        do_reset();
        check("t5_rst_drop", 32'(drop_cnt), 32'd0);
        pulse(4'b1000);
        tick();
        pulse(4'b1000);
        tick();
        check("t5_sig", 32'(int_sig), 32'd1);
        check("t5_vec", 32'(vec_idx), 32'd3);
        ack();
        check("t5_pend_kept", 32'(pending), 32'h8);
        check("t5_drop_none", 32'(drop_cnt), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        tick();
        done();
        check("t5_done_busy", 32'(busy), 32'd0);
        tick();
        check("t5_rereq_sig", 32'(int_sig), 32'd1);
        check("t5_rereq_vec", 32'(vec_idx), 32'd3);
        ack();
        done();

        // Mid-operation reset while in SERVICE
        pulse(4'b0010);
        ticks(3);
        check("t6_sig", 32'(int_sig), 32'd1);
        ack();
        pulse(4'b0110);
        ticks(2);
        check("t6_pend", 32'(pending), 32'h6);
        check("t6_busy", 32'(busy), 32'd1);
        do_reset();
        check("t6_rst_sig", 32'(int_sig), 32'd0);
        check("t6_rst_vec", 32'(vec_idx), 32'd0);
        check("t6_rst_pend", 32'(pending), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_drop", 32'(drop_cnt), 32'd0);
        done();
        ticks(4);
        check("t6_stray_done_sig", 32'(int_sig), 32'd0);
        check("t6_stray_done_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
